ysyx_24090013_ifu: RTL and testbench
====================================

Name: ysyx_24090013_ifu

Overview:
Parametrised instruction fetch unit that replaces the bare PC register and combinational ROM read of the single-cycle core. It issues pipelined fetch requests to instruction memory over a valid/ready request channel and an in-order response channel, and buffers returned instructions in a prefetch FIFO. It hands the instructions to decode over a valid/ready interface and supports a redirect from execute that flushes in-flight fetches.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h8000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of two, >=2; also the maximum number of requests in flight

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address, word aligned
imem_rsp_valid  in  1  response valid; always accepted, no backpressure
imem_rsp_data  in  32  instruction word
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  32  instruction word
inst_pc  out  XLEN  PC of inst_data
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and treated as 0

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - FIFO count=0, outstanding=0, drop_cnt=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=RESET_PC.
  - Reset mid-transaction abandons everything; responses arriving after reset release with drop_cnt=0 are undefined (memory is reset together).
- Credit rule: imem_req_valid = !redirect_valid && (count + outstanding < FIFO_DEPTH). This guarantees no FIFO overflow.
- imem_req_addr = fetch_pc.
- Request fire (valid && ready): fetch_pc += 4 (wraps mod 2^XLEN), outstanding += 1.
- Response (imem_rsp_valid):
  - Always decrements outstanding.
  - If drop_cnt>0: discarded, drop_cnt -= 1.
  - Otherwise pushed as {imem_rsp_data, rsp_pc}, then rsp_pc += 4.
  - Responses return in request order, at least one cycle after their request fires; a same-cycle request fire and response net outstanding unchanged.
- Output: inst_valid = (count!=0) && !redirect_valid. inst_data/inst_pc show the FIFO head when count!=0, and 0/rsp_pc otherwise.
- Pop on inst_valid && inst_ready. Simultaneous push and pop keeps count unchanged; this is legal when full.
- Latency: response to inst_valid is 1 cycle (registered FIFO). Reset release to first imem_req_valid is 0 cycles.
- Redirect cycle:
  - No request issued, no pop.
  - Same-cycle response is treated as dropped.
  - Next state: count=0, fetch_pc=rsp_pc={redirect_pc[XLEN-1:2],2'b0}, drop_cnt = outstanding minus (1 if a response arrived this cycle), with any prior drop_cnt subsumed.
  - Back-to-back redirects are legal; the last one wins.
- Response with outstanding==0: protocol error, ignored; a simulation assertion fires.
- Counters are sized $clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.

Optional Feature:
IFU_ACCESS_FAULT_EN.
- Defined:
  - Adds input imem_rsp_err (1) and output inst_fault (1), stored per FIFO entry.
  - An accepted non-dropped response with err=1 is pushed with fault=1, and new requests stop (halted) until the next redirect.
  - inst_fault is 0 at reset and when empty.
- Undefined: neither port exists and no halt logic is built.

Test Plan:
1. Reset with imem_req_ready=1, rsp 1 cycle later carrying data=PC-derived, inst_ready=1 -> first imem_req_addr=0x8000_0000; inst_pc sequence 0x80000000, 0x80000004, ...; one instruction per cycle once streaming.
2. inst_ready=0 held -> exactly 4 requests issued (count+outstanding=4), then imem_req_valid=0; inst_ready=1 for one cycle -> exactly one more request issued.
3. 2 requests outstanding, redirect_pc=0x8000_0103 -> next imem_req_addr=0x8000_0100; the two late responses are dropped; first inst_pc=0x8000_0100.
4. Redirect in the same cycle a response arrives with 3 outstanding -> drop_cnt=2; inst_valid=0 in the redirect cycle; no stale instruction reaches decode.
5. fetch_pc=0xFFFF_FFFC (XLEN=32) -> next address 0x0000_0000; assert rst mid-stream -> outputs return to reset values immediately, without a clock edge.
6. IFU_ACCESS_FAULT_EN, err=1 on the response for 0x8000_0008 -> inst_fault=1 with inst_pc=0x8000_0008; no further requests until redirect, then fetch resumes.

Source files
------------

// File: rtl/ysyx_24090013_ifu.sv
// ysyx_24090013_ifu: pipelined instruction fetch unit with prefetch FIFO.
// Issues fetches over a valid/ready request channel, buffers in-order
// responses and hands instructions to decode; redirect flushes in-flight work.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   imem_req_valid/ready/addr fetch request channel (word-aligned address)
//   imem_rsp_valid/data       in-order response channel, no backpressure
//   inst_valid/ready/data/pc  instruction hand-off to decode
//   redirect_valid/pc         flush and restart fetch at redirect_pc
//
// Optional build macro IFU_ACCESS_FAULT_EN adds imem_rsp_err / inst_fault.
// A faulting response is tagged in the FIFO and halts fetch until redirect.
module ysyx_24090013_ifu #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
`ifdef IFU_ACCESS_FAULT_EN
    input  logic            imem_rsp_err,
    output logic            inst_fault,
`endif
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redir_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];

    logic [CW:0]     inflight;
    logic            credit_ok;
    logic            halted;
    logic            req_fire;
    logic            rsp_accept;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            not_empty;

    // FIFO occupancy plus requests in flight bounds every future push,
    // so the FIFO can never overflow.
    assign inflight  = {1'b0, count} + {1'b0, outstanding};
    assign credit_ok = inflight < (CW+1)'(FIFO_DEPTH);
    assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign not_empty = count != '0;

    assign imem_req_valid = !rst && !redirect_valid && credit_ok && !halted;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and ignored.
    assign rsp_accept = imem_rsp_valid && (outstanding != '0);
    // Responses in the redirect cycle belong to the old stream.
    assign rsp_drop   = rsp_accept && (redirect_valid || drop_cnt != '0);
    assign push       = rsp_accept && !rsp_drop;

    assign inst_valid = not_empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    assign inst_data  = not_empty ? fifo_data[rd_ptr] : 32'd0;
    assign inst_pc    = not_empty ? fifo_pc[rd_ptr] : rsp_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            // No request fires during redirect, so this holds in all cycles.
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
            if (redirect_valid) begin
                fetch_pc <= redir_pc;
                rsp_pc   <= redir_pc;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                // Everything still in flight after this cycle is stale.
                drop_cnt <= outstanding - CW'(rsp_accept);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef IFU_ACCESS_FAULT_EN
    logic fifo_fault [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_fault[wr_ptr] <= imem_rsp_err;
        end
    end

    // Stop fetching past a faulting fetch; only a redirect can resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= 1'b0;
        end else if (push && imem_rsp_err) begin
            halted <= 1'b1;
        end
    end

    assign inst_fault = not_empty ? fifo_fault[rd_ptr] : 1'b0;
`else
    assign halted = 1'b0;
`endif

`ifndef SYNTHESIS
    rsp_without_request: assert property (
        @(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0)
    );
`endif

endmodule

// File: tb/tb_ysyx_24090013_ifu.sv
// tb_ysyx_24090013_ifu: directed self-checking bench for the fetch unit.
// Inputs change at posedge+2; an optional auto memory answers at posedge+1.
module tb_ysyx_24090013_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_ACCESS_FAULT_EN
    logic        imem_rsp_err;
    logic        inst_fault;
`endif

    logic        mem_auto;
    logic        auto_v;
    logic [31:0] auto_d;
    logic        auto_e;
    logic        man_v;
    logic [31:0] man_d;
    logic [31:0] err_addr;
    logic [31:0] q[$];
    int          fire_cnt;
    int          checks;
    int          errors;

    assign imem_rsp_valid = mem_auto ? auto_v : man_v;
    assign imem_rsp_data  = mem_auto ? auto_d : man_d;
`ifdef IFU_ACCESS_FAULT_EN
    assign imem_rsp_err   = mem_auto ? auto_e : 1'b0;
`endif

    ysyx_24090013_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
`ifdef IFU_ACCESS_FAULT_EN
        .imem_rsp_err   (imem_rsp_err),
        .inst_fault     (inst_fault),
`endif
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle latency, data = ~address.
    always @(posedge clk) begin
        if (!rst && mem_auto && imem_req_valid && imem_req_ready) begin
            q.push_back(imem_req_addr);
            fire_cnt++;
        end
        #1;
        if (mem_auto && q.size() > 0) begin
            auto_v = 1'b1;
            auto_d = ~q[0];
            auto_e = (q[0] == err_addr);
            void'(q.pop_front());
        end else begin
            auto_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        man_v = 1'b0;
        man_d = 32'd0;
        mem_auto = 1'b0;
        err_addr = 32'hFFFF_FFFF;
        tick();
        tick();
        q.delete();
        fire_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        man_v = 1'b0;
        man_d = 32'd0;
        mem_auto = 1'b0;
        err_addr = 32'hFFFF_FFFF;
        tick();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b exp 0", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL reset_req_addr got %h exp 80000000", imem_req_addr);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_inst_valid got %b exp 0", inst_valid);
        end
        checks++;
        if (inst_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_inst_data got %h exp 0", inst_data);
        end
        checks++;
        if (inst_pc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL reset_inst_pc got %h exp 80000000", inst_pc);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        bit found;
        do_reset();
        mem_auto = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL stream_first_req got v=%b a=%h exp v=1 a=80000000",
                     imem_req_valid, imem_req_addr);
        end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = inst_valid;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stream_timeout got no inst_valid exp inst_valid=1");
        end
        exp_pc = 32'h8000_0000;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
                errors++;
                $display("FAIL stream_pc got v=%b pc=%h exp v=1 pc=%h",
                         inst_valid, inst_pc, exp_pc);
            end
            checks++;
            if (inst_data !== ~exp_pc) begin
                errors++;
                $display("FAIL stream_data got %h exp %h", inst_data, ~exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            tick();
        end
    endtask

    task automatic test_credit();
        do_reset();
        mem_auto = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        repeat (8) tick();
        checks++;
        if (fire_cnt !== 4) begin
            errors++;
            $display("FAIL credit_fires got %0d exp 4", fire_cnt);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL credit_req_valid got %b exp 0", imem_req_valid);
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL credit_head got v=%b pc=%h exp v=1 pc=80000000",
                     inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        repeat (6) tick();
        checks++;
        if (fire_cnt !== 5) begin
            errors++;
            $display("FAIL credit_refill got %0d exp 5", fire_cnt);
        end
        checks++;
        if (inst_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL credit_after_pop got pc=%h rv=%b exp pc=80000004 rv=0",
                     inst_pc, imem_req_valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_valid got %b exp 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_addr !== 32'h8000_0100) begin
            errors++;
            $display("FAIL redir_addr got %h exp 80000100", imem_req_addr);
        end
        checks++;
        if (inst_pc !== 32'h8000_0100 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_empty got v=%b pc=%h exp v=0 pc=80000100",
                     inst_valid, inst_pc);
        end
        man_v = 1'b1;
        man_d = 32'hDEAD_0000;
        tick();
        man_d = 32'hDEAD_0004;
        tick();
        man_v = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_drop got v=%b exp 0", inst_valid);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        man_v = 1'b1;
        man_d = 32'h0000_1234;
        tick();
        man_v = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100) begin
            errors++;
            $display("FAIL redir_first got v=%b pc=%h exp v=1 pc=80000100",
                     inst_valid, inst_pc);
        end
        checks++;
        if (inst_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL redir_data got %h exp 00001234", inst_data);
        end
    endtask

    task automatic test_redirect_with_rsp();
        do_reset();
        imem_req_ready = 1'b1;
        repeat (4) tick();
        imem_req_ready = 1'b0;
        man_v = 1'b1;
        man_d = 32'hAAAA_0000;
        tick();
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_pre got v=%b exp 1", inst_valid);
        end
        man_d = 32'hAAAA_0004;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_redirect_cycle got v=%b exp 0", inst_valid);
        end
        tick();
        redirect_valid = 1'b0;
        man_v = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst_pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL rr_after got v=%b pc=%h exp v=0 pc=80000200",
                     inst_valid, inst_pc);
        end
        man_v = 1'b1;
        man_d = 32'hAAAA_0008;
        tick();
        man_d = 32'hAAAA_000C;
        tick();
        man_v = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_stale got v=%b pc=%h exp v=0", inst_valid, inst_pc);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        man_v = 1'b1;
        man_d = 32'h5555_0200;
        tick();
        man_v = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0200 ||
            inst_data !== 32'h5555_0200) begin
            errors++;
            $display("FAIL rr_fresh got v=%b pc=%h d=%h exp v=1 pc=80000200 d=55550200",
                     inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_start got %h exp fffffffc", imem_req_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_next got %h exp 00000000", imem_req_addr);
        end
        man_v = 1'b1;
        man_d = 32'h0BAD_F00D;
        tick();
        man_v = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_inst got v=%b pc=%h exp v=1 pc=fffffffc",
                     inst_valid, inst_pc);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL async_rst_req got v=%b a=%h exp v=0 a=80000000",
                     imem_req_valid, imem_req_addr);
        end
        checks++;
        if (inst_valid !== 1'b0 || inst_data !== 32'd0 ||
            inst_pc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL async_rst_inst got v=%b d=%h pc=%h exp v=0 d=0 pc=80000000",
                     inst_valid, inst_data, inst_pc);
        end
        tick();
        rst = 1'b0;
    endtask

`ifdef IFU_ACCESS_FAULT_EN
    task automatic test_fault();
        int fc;
        bit found;
        do_reset();
        err_addr = 32'h8000_0008;
        mem_auto = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (inst_valid && inst_pc == 32'h8000_0008) found = 1;
            else if (inst_valid && inst_fault !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL fault_early got fault=1 pc=%h exp fault=0", inst_pc);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL fault_timeout got no pc 80000008 exp pc 80000008");
        end
        checks++;
        if (inst_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_flag got %b exp 1", inst_fault);
        end
        fc = fire_cnt;
        repeat (6) tick();
        checks++;
        if (fire_cnt !== fc || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_halt got fires=%0d rv=%b exp fires=%0d rv=0",
                     fire_cnt, imem_req_valid, fc);
        end
        checks++;
        if (inst_valid !== 1'b0 || inst_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_empty got v=%b f=%b exp v=0 f=0",
                     inst_valid, inst_fault);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0040;
        tick();
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = inst_valid;
        end
        checks++;
        if (!found || inst_pc !== 32'h8000_0040 || inst_fault !== 1'b0 ||
            inst_data !== ~32'h8000_0040) begin
            errors++;
            $display("FAIL fault_resume got v=%b pc=%h f=%b d=%h exp v=1 pc=80000040 f=0",
                     inst_valid, inst_pc, inst_fault, inst_data);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        fire_cnt = 0;
        auto_v = 1'b0;
        auto_d = 32'd0;
        auto_e = 1'b0;
        test_reset();
        test_stream();
        test_credit();
        test_redirect();
        test_redirect_with_rsp();
        test_wrap_and_async_reset();
`ifdef IFU_ACCESS_FAULT_EN
        test_fault();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
